mem_slice: RTL and testbench
============================

MEM_SLICE -- requirements
Module: mem_slice

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, maximum BUSY cycles waited for dmem_ready before the access is abandoned (range 1..255).
REQ-002 SHALL have ports: clk  input  1  clock, all state updates on its rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 stall_in  input  1  downstream/global hold; pipeline register keeps its contents.
REQ-005 WB_in  input  7  writeback bundle: [3:0] dest reg, [4] RegWrite, [5] MemToReg, [6] Halt.
REQ-006 M_in  input  3  memory control: [0] MemRead, [1] MemWrite, [2] reserved (ignored).
REQ-007 addr_in, data_in, result_in  input  16 each  EX-stage address, store data, ALU result.
REQ-008 dmem_req, dmem_we  output  1 each  access request and write-enable to data memory.
REQ-009 dmem_addr, dmem_wdata  output  16 each  latched address and store data.
REQ-010 dmem_rdata  input  16  load data, valid when dmem_ready=1; dmem_ready  input  1  access complete.
REQ-011 stall_out  output  1  holds EX and earlier stages; WB  output  7  bundle to writeback; wb_data  output  16  writeback value; mem_err  output  1  sticky error.

Function
REQ-012 Pipeline register (WB, M, addr, data, result) SHALL load on a rising edge when !stall_in && !stall_out, else hold.
REQ-013 FSM SHALL have states IDLE and BUSY; IDLE->BUSY on the same edge that loads a bundle with MemRead or MemWrite set.
REQ-014 In BUSY: dmem_req=1, dmem_we=latched MemWrite, stall_out=1; in IDLE: dmem_req=0, dmem_we=0, stall_out=0.
REQ-015 BUSY->IDLE on an edge where dmem_ready=1; for a read, dmem_rdata SHALL be captured into a load register on that edge.
REQ-016 Minimum memory-op cost SHALL be one stall cycle (ready in first BUSY cycle); no stall for non-memory bundles.
REQ-017 While BUSY, WB output SHALL be 7'h00 (bubble); in IDLE, WB SHALL equal the latched WB bundle.
REQ-018 wb_data SHALL be the load register when latched MemToReg=1, else latched result.
REQ-019 A 8-bit cycle counter SHALL clear on BUSY entry and increment each BUSY cycle; at TIMEOUT_CYCLES without ready: BUSY->IDLE, mem_err<=1, load register<=16'hFFFF.
REQ-020 dmem_ready and timeout in the same cycle: ready SHALL win, no error.
REQ-021 MemRead and MemWrite both set: SHALL execute as a write and set mem_err.
REQ-022 stall_in during BUSY SHALL NOT pause the FSM; completion is recorded and the register holds until stall_in drops.
REQ-023 dmem_ready while IDLE SHALL be ignored.

Reset
REQ-024 On rst: state IDLE, all pipeline register fields, load register, counter and mem_err = 0; hence WB=7'h00, wb_data=16'h0000, dmem_req=0, stall_out=0 in the following cycle.
REQ-025 rst asserted mid-BUSY SHALL abandon the access without setting mem_err.

Configuration
REQ-026 Macro MEM_FWD_EN: defined -> ports fwd_valid (1), fwd_rd (4), fwd_data (16) exist, equal to (latched RegWrite && state==IDLE), latched dest reg, wb_data; undefined -> ports and logic absent, other behaviour identical.

Structure
REQ-027 Shared package cpu_pkg SHALL hold WB/M bit-index constants, the IDLE/BUSY state enum, and TIMEOUT default.
REQ-028 The FSM, counter and timeout SHALL live in one sub-module dmem_handshake; mem_slice holds the pipeline register and output muxing.

Verification
REQ-029 ALU op: WB_in=7'h13 (RegWrite, rd=3), M_in=0, result_in=16'h1234 -> next cycle WB=7'h13, wb_data=16'h1234, stall_out=0.
REQ-030 Load: M_in=3'b001, WB_in=7'h35, addr_in=16'h0040, ready after 3 BUSY cycles with rdata=16'hBEEF -> stall_out=1 for 3 cycles, dmem_addr=16'h0040, then wb_data=16'hBEEF.
REQ-031 Store: M_in=3'b010, data_in=16'hA5A5, ready first cycle -> one stall cycle, dmem_we=1, dmem_wdata=16'hA5A5.
REQ-032 Timeout: load, dmem_ready held 0 -> after 15 BUSY cycles IDLE, mem_err=1, wb_data=16'hFFFF; ready on cycle 15 -> no error.
REQ-033 rst on 2nd BUSY cycle -> next cycle dmem_req=0, WB=0, mem_err=0.
REQ-034 MEM_FWD_EN defined, load rd=5 completing -> fwd_valid=1, fwd_rd=5, fwd_data=load value only after BUSY ends.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared bit indices, FSM state type and timeout default for the memory stage
package cpu_pkg;

  // Writeback bundle layout
  localparam int WB_W        = 7;
  localparam int WB_RD_LSB   = 0;
  localparam int WB_RD_W     = 4;
  localparam int WB_REGWRITE = 4;
  localparam int WB_MEMTOREG = 5;
  localparam int WB_HALT     = 6;

  // Memory control layout (bit 2 is reserved)
  localparam int M_W     = 3;
  localparam int M_READ  = 0;
  localparam int M_WRITE = 1;

  localparam int DATA_W          = 16;
  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_handshake.sv
// rtl/dmem_handshake.sv - IDLE/BUSY data-memory handshake with timeout, load register and sticky error
module dmem_handshake
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_conflict,
  input  logic              op_read,
  input  logic              op_write,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              busy,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_err
);

  // Counter value seen during the last BUSY cycle allowed before abandoning
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   load_q, load_d;
  logic                err_q, err_d;

  // Next-state: enter BUSY on a memory bundle load; leave on ready (which beats timeout) or on timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          if (start_conflict) err_d = 1'b1;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_ready) begin
          state_d = ST_IDLE;
          if (op_read && !op_write) load_d = dmem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          load_d  = 16'hFFFF;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, load register and error flag; reset abandons any access quietly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign load_data = load_q;
  assign mem_err   = err_q;

endmodule

// File: rtl/mem_slice.sv
// rtl/mem_slice.sv - memory pipeline stage; optional forwarding ports under MEM_FWD_EN
module mem_slice
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic [6:0]  WB_in,
  input  logic [2:0]  M_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] data_in,
  input  logic [15:0] result_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_out,
  output logic [6:0]  WB,
  output logic [15:0] wb_data,
  output logic        mem_err
`ifdef MEM_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [3:0]  fwd_rd,
  output logic [15:0] fwd_data
`endif
);

  logic [WB_W-1:0]   wb_q, wb_d;
  logic [1:0]        m_q, m_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              load_en;
  logic              busy;
  logic [DATA_W-1:0] load_data;
  logic              unused_m_rsvd;

  assign unused_m_rsvd = M_in[2];
  assign load_en       = !stall_in && !stall_out;

  // Pipeline register captures the EX bundle only when neither side is holding
  always_comb begin
    wb_d     = wb_q;
    m_d      = m_q;
    addr_d   = addr_q;
    data_d   = data_q;
    result_d = result_q;
    if (load_en) begin
      wb_d     = WB_in;
      m_d      = {M_in[M_WRITE], M_in[M_READ]};
      addr_d   = addr_in;
      data_d   = data_in;
      result_d = result_in;
    end
  end

  // Pipeline register flops
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      m_q      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      wb_q     <= wb_d;
      m_q      <= m_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  dmem_handshake #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_hs (
    .clk            (clk),
    .rst            (rst),
    .start          (load_en && (M_in[M_READ] || M_in[M_WRITE])),
    .start_conflict (M_in[M_READ] && M_in[M_WRITE]),
    .op_read        (m_q[0]),
    .op_write       (m_q[1]),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata),
    .busy           (busy),
    .load_data      (load_data),
    .mem_err        (mem_err)
  );

  // Memory-side outputs only active while an access is outstanding; writeback bubbles during BUSY
  always_comb begin
    stall_out  = busy;
    dmem_req   = busy;
    dmem_we    = busy && m_q[1];
    dmem_addr  = addr_q;
    dmem_wdata = data_q;
    WB         = busy ? '0 : wb_q;
    wb_data    = wb_q[WB_MEMTOREG] ? load_data : result_q;
  end

`ifdef MEM_FWD_EN
  // Forward the completed writeback value only once the access has finished
  always_comb begin
    fwd_valid = wb_q[WB_REGWRITE] && !busy;
    fwd_rd    = wb_q[WB_RD_LSB +: WB_RD_W];
    fwd_data  = wb_data;
  end
`endif

endmodule

// File: tb/tb_mem_slice.sv
// tb/tb_mem_slice.sv - scoreboard bench for mem_slice
module tb_mem_slice;

  localparam int TMO = 15;

  typedef struct {
    logic [6:0]  wb;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic [6:0]  WB_in;
  logic [2:0]  M_in;
  logic [15:0] addr_in, data_in, result_in;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        stall_out;
  logic [6:0]  WB;
  logic [15:0] wb_data;
  logic        mem_err;
`ifdef MEM_FWD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [15:0] fwd_data;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [15:0] load_model;
  logic        err_model;

  always #5 clk = ~clk;

  mem_slice #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .WB_in(WB_in), .M_in(M_in),
    .addr_in(addr_in), .data_in(data_in), .result_in(result_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall_out(stall_out),
    .WB(WB), .wb_data(wb_data), .mem_err(mem_err)
`ifdef MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_cmp++; if (WB !== 7'h00) begin n_bad++; $display("FAIL reset_wb: got %h exp 00", WB); end
    n_cmp++; if (wb_data !== 16'h0000) begin n_bad++; $display("FAIL reset_wb_data: got %h exp 0000", wb_data); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b exp 0", dmem_req); end
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b exp 0", stall_out); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", mem_err); end
    rst = 1'b0;
    load_model = 16'h0000;
    err_model  = 1'b0;
  endtask

  // Drives one bundle, responds with ready on BUSY cycle ready_at (0 = never), checks completion
  task automatic do_op(input string name, input logic [6:0] wb, input logic [2:0] m,
                       input logic [15:0] addr, input logic [15:0] dat, input logic [15:0] res,
                       input int ready_at, input logic [15:0] rdata);
    exp_t e;
    int   stalls;
    int   exp_stalls;
    logic is_mem, tmo;
    is_mem     = m[0] | m[1];
    tmo        = is_mem && (ready_at == 0 || ready_at > TMO);
    exp_stalls = !is_mem ? 0 : (tmo ? TMO : ready_at);
    if (tmo) load_model = 16'hFFFF;
    else if (is_mem && m[0] && !m[1]) load_model = rdata;
    err_model = err_model | tmo | (m[0] & m[1]);
    e.wb   = wb;
    e.data = wb[5] ? load_model : res;
    e.err  = err_model;
    sb.push_back(e);

    WB_in = wb; M_in = m; addr_in = addr; data_in = dat; result_in = res;
    step();
    WB_in = 7'h00; M_in = 3'b000;
    stalls = 0;
    while (stall_out === 1'b1 && stalls < 300) begin
      if (stalls == 0) begin
        n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL %s req: got %b exp 1", name, dmem_req); end
        n_cmp++; if (dmem_we !== m[1]) begin n_bad++; $display("FAIL %s we: got %b exp %b", name, dmem_we, m[1]); end
        n_cmp++; if (dmem_addr !== addr) begin n_bad++; $display("FAIL %s addr: got %h exp %h", name, dmem_addr, addr); end
        n_cmp++; if (dmem_wdata !== dat) begin n_bad++; $display("FAIL %s wdata: got %h exp %h", name, dmem_wdata, dat); end
        n_cmp++; if (WB !== 7'h00) begin n_bad++; $display("FAIL %s bubble: got %h exp 00", name, WB); end
      end
      stalls++;
      dmem_ready = (stalls == ready_at);
      dmem_rdata = rdata;
      step();
    end
    dmem_ready = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (stalls != exp_stalls) begin n_bad++; $display("FAIL %s stalls: got %0d exp %0d", name, stalls, exp_stalls); end
    n_cmp++; if (WB !== e.wb) begin n_bad++; $display("FAIL %s wb: got %h exp %h", name, WB, e.wb); end
    n_cmp++; if (wb_data !== e.data) begin n_bad++; $display("FAIL %s wb_data: got %h exp %h", name, wb_data, e.data); end
    n_cmp++; if (mem_err !== e.err) begin n_bad++; $display("FAIL %s err: got %b exp %b", name, mem_err, e.err); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL %s idle_req: got %b exp 0", name, dmem_req); end
  endtask

  task automatic test_alu();
    do_op("alu", 7'h13, 3'b000, 16'h0000, 16'h0000, 16'h1234, 0, 16'h0000);
  endtask

  task automatic test_load();
    do_op("load", 7'h35, 3'b001, 16'h0040, 16'h0000, 16'h9999, 3, 16'hBEEF);
  endtask

  task automatic test_store();
    do_op("store", 7'h00, 3'b010, 16'h0080, 16'hA5A5, 16'h0080, 1, 16'h0000);
  endtask

  task automatic test_ready_idle();
    dmem_ready = 1'b1;
    dmem_rdata = 16'h7777;
    WB_in = 7'h22; M_in = 3'b000; result_in = 16'h0101;
    step();
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL ready_idle stall: got %b exp 0", stall_out); end
    n_cmp++; if (wb_data !== load_model) begin n_bad++; $display("FAIL ready_idle wb_data: got %h exp %h", wb_data, load_model); end
    dmem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_op("b2b_ld1", 7'h31, 3'b001, 16'h0100, 16'h0000, 16'h0000, 1, 16'h1111);
    do_op("b2b_ld2", 7'h32, 3'b101, 16'h0102, 16'h0000, 16'h0000, 2, 16'h2222);
    do_op("b2b_alu", 7'h53, 3'b100, 16'h0000, 16'h0000, 16'h4321, 0, 16'h0000);
  endtask

  task automatic test_stall_in();
    stall_in = 1'b1;
    WB_in = 7'h35; M_in = 3'b001; addr_in = 16'h0200; result_in = 16'hDEAD;
    step();
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL stall_in hold_busy: got %b exp 0", stall_out); end
    n_cmp++; if (WB !== 7'h53) begin n_bad++; $display("FAIL stall_in hold_wb: got %h exp 53", WB); end
    stall_in = 1'b0;
    step();
    stall_in = 1'b1;
    WB_in = 7'h13; M_in = 3'b000; result_in = 16'h5555;
    step();
    dmem_ready = 1'b1; dmem_rdata = 16'hCAFE;
    step();
    dmem_ready = 1'b0;
    load_model = 16'hCAFE;
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL stall_in done: got %b exp 0", stall_out); end
    n_cmp++; if (WB !== 7'h35 || wb_data !== 16'hCAFE) begin n_bad++; $display("FAIL stall_in result: got %h/%h exp 35/cafe", WB, wb_data); end
    step();
    n_cmp++; if (WB !== 7'h35) begin n_bad++; $display("FAIL stall_in held: got %h exp 35", WB); end
    stall_in = 1'b0;
    step();
    n_cmp++; if (WB !== 7'h13 || wb_data !== 16'h5555) begin n_bad++; $display("FAIL stall_in release: got %h/%h exp 13/5555", WB, wb_data); end
    WB_in = 7'h00;
  endtask

  task automatic test_conflict();
    do_op("conflict", 7'h00, 3'b011, 16'h0300, 16'h3C3C, 16'h0300, 1, 16'hABCD);
  endtask

  task automatic test_timeout();
    do_op("timeout", 7'h35, 3'b001, 16'h0400, 16'h0000, 16'h0000, 0, 16'h0000);
    test_reset();
    do_op("timeout_edge", 7'h35, 3'b001, 16'h0404, 16'h0000, 16'h0000, TMO, 16'h1357);
  endtask

  task automatic test_rst_mid_busy();
    WB_in = 7'h35; M_in = 3'b001; addr_in = 16'h0500;
    step();
    WB_in = 7'h00; M_in = 3'b000;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_busy req: got %b exp 0", dmem_req); end
    n_cmp++; if (WB !== 7'h00) begin n_bad++; $display("FAIL rst_busy wb: got %h exp 00", WB); end
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rst_busy err: got %b exp 0", mem_err); end
    load_model = 16'h0000;
    err_model  = 1'b0;
  endtask

`ifdef MEM_FWD_EN
  task automatic test_fwd();
    WB_in = 7'h35; M_in = 3'b001; addr_in = 16'h0600;
    step();
    WB_in = 7'h00; M_in = 3'b000;
    n_cmp++; if (fwd_valid !== 1'b0) begin n_bad++; $display("FAIL fwd busy_valid: got %b exp 0", fwd_valid); end
    dmem_ready = 1'b1; dmem_rdata = 16'h0F0F;
    step();
    dmem_ready = 1'b0;
    n_cmp++; if (fwd_valid !== 1'b1 || fwd_rd !== 4'd5 || fwd_data !== 16'h0F0F) begin
      n_bad++; $display("FAIL fwd done: got %b/%0d/%h exp 1/5/0f0f", fwd_valid, fwd_rd, fwd_data);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; stall_in = 1'b0; WB_in = '0; M_in = '0;
    addr_in = '0; data_in = '0; result_in = '0;
    dmem_rdata = '0; dmem_ready = 1'b0;
    load_model = '0; err_model = 1'b0;
    step();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ready_idle();
    test_back_to_back();
    test_stall_in();
    test_conflict();
    test_reset();
    test_timeout();
    test_rst_mid_busy();
`ifdef MEM_FWD_EN
    test_fwd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
